io_responder: RTL and testbench

IO_RESPONDER -- requirements
Module: io_responder

---
 rtl/io_map_pkg.sv | 31 +++
 rtl/switch_debouncer.sv | 54 +++++
 rtl/io_responder.sv | 90 +++++++++
 tb/tb_io_responder.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_map_pkg.sv
// Address map and register-select decode for the 0xFFFF_xxxx IO responder.
package io_map_pkg;

  localparam logic [15:0] IO_REGION_HI = 16'hFFFF;
  localparam logic [15:0] ADDR_LED     = 16'hFC60;
  localparam logic [15:0] ADDR_SW      = 16'hFC70;
  localparam logic [15:0] ADDR_TIMER   = 16'hFC80;
  localparam logic [15:0] ADDR_STATUS  = 16'hFC90;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_LED,
    SEL_SW,
    SEL_TIMER,
    SEL_STATUS
  } reg_sel_e;

  // The strobes already qualify the high half; rebuild the full address for decode.
  function automatic reg_sel_e decode_addr(input logic [15:0] addr);
    logic [31:0] full_addr;
    full_addr = {IO_REGION_HI, addr};
    case (full_addr)
      {IO_REGION_HI, ADDR_LED}:    return SEL_LED;
      {IO_REGION_HI, ADDR_SW}:     return SEL_SW;
      {IO_REGION_HI, ADDR_TIMER}:  return SEL_TIMER;
      {IO_REGION_HI, ADDR_STATUS}: return SEL_STATUS;
      default:                     return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/switch_debouncer.sv
// Two-flop synchronizer followed by a stable-count debouncer for the board switches.
module switch_debouncer #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int SW_W            = 24
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [SW_W-1:0] sw_in,
  output logic [SW_W-1:0] sw_db,
  output logic            sw_change
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SW_W-1:0]  sync1_q, sync1_d;
  logic [SW_W-1:0]  sync2_q, sync2_d;
  logic [SW_W-1:0]  db_q, db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A pending change in the synchronizer (sync1 != sync2) restarts the count.
  always_comb begin
    sync1_d   = sw_in;
    sync2_d   = sync1_q;
    db_d      = db_q;
    cnt_d     = '0;
    sw_change = 1'b0;
    if ((sync2_q != db_q) && (sync1_q == sync2_q)) begin
      if (cnt_q == CNT_LAST) begin
        db_d      = sync2_q;
        sw_change = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      db_q    <= '0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sw_db = db_q;

endmodule

// File: rtl/io_responder.sv
// Memory-mapped IO responder: LED register, debounced switches, free-running timer
// and a clear-on-read switch-change status flag.
module io_responder
  import io_map_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int SW_W            = 24
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            io_read,
  input  logic            io_write,
  input  logic [15:0]     io_addr,
  input  logic [31:0]     io_wdata,
  output logic [31:0]     io_rdata,
  input  logic [SW_W-1:0] sw_in,
  output logic [SW_W-1:0] led_out
);

  logic [SW_W-1:0] led_q, led_d;
  logic [31:0]     timer_q, timer_d;
  logic            sw_changed_q, sw_changed_d;
  logic [SW_W-1:0] sw_db;
  logic            sw_change;
  logic            rd_ok;
  logic            wr_ok;
  reg_sel_e        sel;

  switch_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SW_W           (SW_W)
  ) u_debouncer (
    .clock    (clock),
    .reset    (reset),
    .sw_in    (sw_in),
    .sw_db    (sw_db),
    .sw_change(sw_change)
  );

  // Simultaneous read and write is an illegal access and is dropped entirely.
  assign rd_ok = io_read & ~io_write;
  assign wr_ok = io_write & ~io_read;
  assign sel   = decode_addr(io_addr);

  always_comb begin
    io_rdata = '0;
    if (rd_ok) begin
      case (sel)
        SEL_LED:    io_rdata = 32'(led_q);
        SEL_SW:     io_rdata = 32'(sw_db);
        SEL_TIMER:  io_rdata = timer_q;
        SEL_STATUS: io_rdata = {31'b0, sw_changed_q};
        default:    io_rdata = '0;
      endcase
    end
  end

  always_comb begin
    led_d        = led_q;
    timer_d      = timer_q + 32'd1;
    sw_changed_d = sw_changed_q;
    if (wr_ok && (sel == SEL_LED)) begin
      led_d = io_wdata[SW_W-1:0];
    end
    if (wr_ok && (sel == SEL_TIMER)) begin
      timer_d = io_wdata;
    end
    // A new change event beats a coincident clearing read.
    if (sw_change) begin
      sw_changed_d = 1'b1;
    end else if (rd_ok && (sel == SEL_STATUS)) begin
      sw_changed_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      led_q        <= '0;
      timer_q      <= '0;
      sw_changed_q <= 1'b0;
    end else begin
      led_q        <= led_d;
      timer_q      <= timer_d;
      sw_changed_q <= sw_changed_d;
    end
  end

  assign led_out = led_q;

endmodule

// File: tb/tb_io_responder.sv
// Directed bench for io_responder with a short debounce window.
module tb_io_responder;

  localparam int DEB  = 4;
  localparam int SW_W = 24;

  logic            clock = 1'b0;
  logic            reset;
  logic            io_read;
  logic            io_write;
  logic [15:0]     io_addr;
  logic [31:0]     io_wdata;
  logic [31:0]     io_rdata;
  logic [SW_W-1:0] sw_in;
  logic [SW_W-1:0] led_out;

  int checks_passed = 0;
  int checks_total  = 0;

  io_responder #(
    .DEBOUNCE_CYCLES(DEB),
    .SW_W           (SW_W)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .io_read (io_read),
    .io_write(io_write),
    .io_addr (io_addr),
    .io_wdata(io_wdata),
    .io_rdata(io_rdata),
    .sw_in   (sw_in),
    .led_out (led_out)
  );

  always #5 clock = ~clock;

  task automatic bus_idle();
    io_read  = 1'b0;
    io_write = 1'b0;
    io_addr  = 16'h0000;
    io_wdata = 32'h0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset    = 1'b1;
    io_write = 1'b1;
    io_addr  = 16'hFC60;
    io_wdata = 32'h00FFFFFF;
    @(negedge clock);
    io_write = 1'b0;
    io_read  = 1'b1;
    io_addr  = 16'hFC80;
    #1;
    checks_total++;
    if (io_rdata !== 32'h0) $display("FAIL reset_timer: got %h expected %h", io_rdata, 32'h0);
    else checks_passed++;
    checks_total++;
    if (led_out !== 24'h0) $display("FAIL reset_led_override: got %h expected %h", led_out, 24'h0);
    else checks_passed++;
    io_addr = 16'hFC90;
    #1;
    checks_total++;
    if (io_rdata !== 32'h0) $display("FAIL reset_status: got %h expected %h", io_rdata, 32'h0);
    else checks_passed++;
    io_addr = 16'hFC70;
    #1;
    checks_total++;
    if (io_rdata !== 32'h0) $display("FAIL reset_sw: got %h expected %h", io_rdata, 32'h0);
    else checks_passed++;
    reset   = 1'b0;
    io_read = 1'b0;
    repeat (3) @(negedge clock);
    io_read = 1'b1;
    io_addr = 16'hFC80;
    #1;
    checks_total++;
    if (io_rdata !== 32'd3) $display("FAIL timer_after_reset: got %h expected %h", io_rdata, 32'd3);
    else checks_passed++;
  endtask

  task automatic test_led();
    @(negedge clock);
    bus_idle();
    io_write = 1'b1;
    io_addr  = 16'hFC60;
    io_wdata = 32'h00A5A5A5;
    @(negedge clock);
    bus_idle();
    #1;
    checks_total++;
    if (led_out !== 24'hA5A5A5) $display("FAIL led_write: got %h expected %h", led_out, 24'hA5A5A5);
    else checks_passed++;
    io_read = 1'b1;
    io_addr = 16'hFC60;
    #1;
    checks_total++;
    if (io_rdata !== 32'h00A5A5A5) $display("FAIL led_read: got %h expected %h", io_rdata, 32'h00A5A5A5);
    else checks_passed++;
    io_read = 1'b0;
    #1;
    checks_total++;
    if (io_rdata !== 32'h0) $display("FAIL rdata_no_read: got %h expected %h", io_rdata, 32'h0);
    else checks_passed++;
    @(negedge clock);
    io_write = 1'b1;
    io_addr  = 16'hFC60;
    io_wdata = 32'hFF123456;
    @(negedge clock);
    io_write = 1'b0;
    #1;
    checks_total++;
    if (led_out !== 24'h123456) $display("FAIL led_truncate: got %h expected %h", led_out, 24'h123456);
    else checks_passed++;
    io_write = 1'b1;
    io_addr  = 16'hFC70;
    io_wdata = 32'h00ABCDEF;
    @(negedge clock);
    io_addr = 16'hFC00;
    @(negedge clock);
    bus_idle();
    #1;
    checks_total++;
    if (led_out !== 24'h123456) $display("FAIL led_ro_write: got %h expected %h", led_out, 24'h123456);
    else checks_passed++;
    io_read = 1'b1;
    io_addr = 16'hFC00;
    #1;
    checks_total++;
    if (io_rdata !== 32'h0) $display("FAIL unmapped_read: got %h expected %h", io_rdata, 32'h0);
    else checks_passed++;
  endtask

  task automatic test_timer();
    logic [31:0] exp_vals [3];
    exp_vals[0] = 32'hFFFF_FFFE;
    exp_vals[1] = 32'hFFFF_FFFF;
    exp_vals[2] = 32'h0000_0000;
    @(negedge clock);
    bus_idle();
    io_write = 1'b1;
    io_addr  = 16'hFC80;
    io_wdata = 32'hFFFF_FFFE;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      io_write = 1'b0;
      io_read  = 1'b1;
      io_addr  = 16'hFC80;
      #1;
      checks_total++;
      if (io_rdata !== exp_vals[k]) $display("FAIL timer_wrap[%0d]: got %h expected %h", k, io_rdata, exp_vals[k]);
      else checks_passed++;
    end
  endtask

  task automatic test_glitch();
    @(negedge clock);
    bus_idle();
    sw_in = 24'h000001;
    repeat (3) @(negedge clock);
    sw_in = 24'h000000;
    repeat (10) @(negedge clock);
    io_read = 1'b1;
    io_addr = 16'hFC70;
    #1;
    checks_total++;
    if (io_rdata !== 32'h0) $display("FAIL glitch_sw: got %h expected %h", io_rdata, 32'h0);
    else checks_passed++;
    io_addr = 16'hFC90;
    #1;
    checks_total++;
    if (io_rdata !== 32'h0) $display("FAIL glitch_status: got %h expected %h", io_rdata, 32'h0);
    else checks_passed++;
  endtask

  task automatic test_debounce_accept();
    logic [31:0] exp_sw;
    @(negedge clock);
    bus_idle();
    sw_in   = 24'h000001;
    io_read = 1'b1;
    io_addr = 16'hFC70;
    for (int k = 0; k <= 6; k++) begin
      if (k > 0) @(negedge clock);
      #1;
      exp_sw = (k == 6) ? 32'h1 : 32'h0;
      checks_total++;
      if (io_rdata !== exp_sw) $display("FAIL debounce_sw[%0d]: got %h expected %h", k, io_rdata, exp_sw);
      else checks_passed++;
    end
    io_addr = 16'hFC90;
    #1;
    checks_total++;
    if (io_rdata !== 32'h1) $display("FAIL status_set: got %h expected %h", io_rdata, 32'h1);
    else checks_passed++;
    @(negedge clock);
    #1;
    checks_total++;
    if (io_rdata !== 32'h0) $display("FAIL status_clear: got %h expected %h", io_rdata, 32'h0);
    else checks_passed++;
  endtask

  task automatic test_status_coincide();
    @(negedge clock);
    bus_idle();
    sw_in = 24'h000000;
    repeat (4) @(negedge clock);
    @(negedge clock);
    io_read = 1'b1;
    io_addr = 16'hFC90;
    #1;
    checks_total++;
    if (io_rdata !== 32'h0) $display("FAIL coincide_read: got %h expected %h", io_rdata, 32'h0);
    else checks_passed++;
    @(negedge clock);
    #1;
    checks_total++;
    if (io_rdata !== 32'h1) $display("FAIL coincide_set_wins: got %h expected %h", io_rdata, 32'h1);
    else checks_passed++;
    io_addr = 16'hFC70;
    #1;
    checks_total++;
    if (io_rdata !== 32'h0) $display("FAIL coincide_sw: got %h expected %h", io_rdata, 32'h0);
    else checks_passed++;
  endtask

  task automatic test_illegal();
    @(negedge clock);
    bus_idle();
    io_read  = 1'b1;
    io_write = 1'b1;
    io_addr  = 16'hFC60;
    io_wdata = 32'h00111111;
    #1;
    checks_total++;
    if (io_rdata !== 32'h0) $display("FAIL illegal_rdata: got %h expected %h", io_rdata, 32'h0);
    else checks_passed++;
    @(negedge clock);
    bus_idle();
    #1;
    checks_total++;
    if (led_out !== 24'h123456) $display("FAIL illegal_led: got %h expected %h", led_out, 24'h123456);
    else checks_passed++;
  endtask

  task automatic test_reset_mid_debounce();
    logic [31:0] exp_sw;
    @(negedge clock);
    bus_idle();
    sw_in = 24'h000001;
    repeat (4) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    io_read = 1'b1;
    io_addr = 16'hFC70;
    #1;
    checks_total++;
    if (io_rdata !== 32'h0) $display("FAIL midreset_sw: got %h expected %h", io_rdata, 32'h0);
    else checks_passed++;
    checks_total++;
    if (led_out !== 24'h0) $display("FAIL midreset_led: got %h expected %h", led_out, 24'h0);
    else checks_passed++;
    io_addr = 16'hFC80;
    #1;
    checks_total++;
    if (io_rdata !== 32'h0) $display("FAIL midreset_timer: got %h expected %h", io_rdata, 32'h0);
    else checks_passed++;
    reset   = 1'b0;
    io_addr = 16'hFC70;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      #1;
      exp_sw = (k == 6) ? 32'h1 : 32'h0;
      checks_total++;
      if (io_rdata !== exp_sw) $display("FAIL midreset_accept[%0d]: got %h expected %h", k, io_rdata, exp_sw);
      else checks_passed++;
    end
    io_addr = 16'hFC90;
    #1;
    checks_total++;
    if (io_rdata !== 32'h1) $display("FAIL midreset_status: got %h expected %h", io_rdata, 32'h1);
    else checks_passed++;
  endtask

  initial begin
    reset = 1'b1;
    sw_in = '0;
    bus_idle();
    test_reset();
    test_led();
    test_timer();
    test_glitch();
    test_debounce_accept();
    test_status_coincide();
    test_illegal();
    test_reset_mid_debounce();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
